exec_pipe_regs: RTL and testbench

Pipeline register bank carrying instruction control and data from Decode through Execute, Memory and Writeback in the 5-stage RV32I core. It produces the stage-tagged source and destination fields (Rs1E, Rs2E, RdM, RdW, RegWriteM, RegWriteW) that the forwarding/hazard unit compares. It also produces the Writeback result mux output used as the W-stage forwarding value. It inserts bubbles on FlushE and suppresses writes to x0 at capture time.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/flopr_clr.sv | 35 +++
 rtl/exec_pipe_regs.sv | 169 ++++++++++++++++
 tb/tb_exec_pipe_regs.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: datapath width, writeback-source encodings
// and the packed per-stage pipeline register layouts.
package riscv_pkg;

    localparam int XLEN = 32;

    // Writeback source select; 2'b11 is reserved and behaves as RES_ALU.
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Decode -> Execute register contents.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc_plus4;
    } ctrl_e_t;

    // Execute -> Memory register contents.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
    } ctrl_m_t;

    // Memory -> Writeback register contents.
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic [4:0]      rd;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus4;
    } ctrl_w_t;

endpackage

// File: rtl/flopr_clr.sv
// Parameterised-width register with asynchronous reset and a synchronous
// clear; the clear loads all zeros (used to insert pipeline bubbles).
module flopr_clr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Next value: zeros when clearing, otherwise the incoming data.
    always_comb begin
        q_d = d;
        if (clr) begin
            q_d = '0;
        end
    end

    // State register; reset is asynchronous and takes priority over clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/exec_pipe_regs.sv
// D->E, E->M and M->W pipeline registers of the 5-stage RV32I core, plus the
// writeback result mux. Optional feature macro: RETIRE_CNT_EN adds the
// RetiredW port and a 32-bit count of instructions entering Writeback.
module exec_pipe_regs
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidD,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] ReadDataM,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ValidE,
    output logic [1:0]      ResultSrcE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ValidM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
    output logic            ValidW,
    output logic [XLEN-1:0] ResultW
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0]     RetiredW
`endif
);

    ctrl_e_t ctrl_e_d, ctrl_e_q;
    ctrl_m_t ctrl_m_d, ctrl_m_q;
    ctrl_w_t ctrl_w_d, ctrl_w_q;

    // D->E capture: an invalid slot becomes a bubble (data still copied);
    // writes to x0 are dropped here so later stages never see them.
    always_comb begin
        ctrl_e_d          = '0;
        ctrl_e_d.pc_plus4 = PCPlus4D;
        if (ValidD) begin
            ctrl_e_d.valid      = 1'b1;
            ctrl_e_d.reg_write  = RegWriteD & (RdD != 5'd0);
            ctrl_e_d.mem_write  = MemWriteD;
            ctrl_e_d.result_src = ResultSrcD;
            ctrl_e_d.rs1        = Rs1D;
            ctrl_e_d.rs2        = Rs2D;
            ctrl_e_d.rd         = RdD;
        end
    end

    // FlushE clears the whole E group, data fields included.
    flopr_clr #(.WIDTH($bits(ctrl_e_t))) u_reg_e (
        .clk   (clk),
        .reset (reset),
        .clr   (FlushE),
        .d     (ctrl_e_d),
        .q     (ctrl_e_q)
    );

    // E->M: copy controls and Execute results; reserved source maps to ALU.
    always_comb begin
        ctrl_m_d            = '0;
        ctrl_m_d.valid      = ctrl_e_q.valid;
        ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
        ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
        ctrl_m_d.result_src = (ctrl_e_q.result_src == 2'b11) ? RES_ALU
                                                              : ctrl_e_q.result_src;
        ctrl_m_d.rd         = ctrl_e_q.rd;
        ctrl_m_d.alu_result = ALUResultE;
        ctrl_m_d.write_data = WriteDataE;
        ctrl_m_d.pc_plus4   = ctrl_e_q.pc_plus4;
    end

    flopr_clr #(.WIDTH($bits(ctrl_m_t))) u_reg_m (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .d     (ctrl_m_d),
        .q     (ctrl_m_q)
    );

    // M->W: copy controls, the ALU result and the memory read data.
    always_comb begin
        ctrl_w_d            = '0;
        ctrl_w_d.valid      = ctrl_m_q.valid;
        ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
        ctrl_w_d.result_src = ctrl_m_q.result_src;
        ctrl_w_d.rd         = ctrl_m_q.rd;
        ctrl_w_d.alu_result = ctrl_m_q.alu_result;
        ctrl_w_d.read_data  = ReadDataM;
        ctrl_w_d.pc_plus4   = ctrl_m_q.pc_plus4;
    end

    flopr_clr #(.WIDTH($bits(ctrl_w_t))) u_reg_w (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .d     (ctrl_w_d),
        .q     (ctrl_w_q)
    );

    // Writeback result select, also the W-stage forwarding value.
    always_comb begin
        case (ctrl_w_q.result_src)
            RES_MEM: ResultW = ctrl_w_q.read_data;
            RES_PC4: ResultW = ctrl_w_q.pc_plus4;
            default: ResultW = ctrl_w_q.alu_result;
        endcase
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] retired_d;
    logic [31:0] retired_q;

    // Count instructions moving from M into W; wraps naturally at 2^32.
    always_comb begin
        retired_d = retired_q;
        if (ctrl_m_q.valid) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign RetiredW = retired_q;
`endif

    assign Rs1E       = ctrl_e_q.rs1;
    assign Rs2E       = ctrl_e_q.rs2;
    assign RdE        = ctrl_e_q.rd;
    assign RegWriteE  = ctrl_e_q.reg_write;
    assign MemWriteE  = ctrl_e_q.mem_write;
    assign ValidE     = ctrl_e_q.valid;
    assign ResultSrcE = ctrl_e_q.result_src;
    assign PCPlus4E   = ctrl_e_q.pc_plus4;

    assign RdM        = ctrl_m_q.rd;
    assign RegWriteM  = ctrl_m_q.reg_write;
    assign MemWriteM  = ctrl_m_q.mem_write;
    assign ValidM     = ctrl_m_q.valid;
    assign ALUResultM = ctrl_m_q.alu_result;
    assign WriteDataM = ctrl_m_q.write_data;

    assign RdW        = ctrl_w_q.rd;
    assign RegWriteW  = ctrl_w_q.reg_write;
    assign ValidW     = ctrl_w_q.valid;

endmodule

// File: tb/tb_exec_pipe_regs.sv
// Directed, table-driven bench for exec_pipe_regs. Build with RETIRE_CNT_EN
// defined to also exercise the RetiredW counter.
module tb_exec_pipe_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        ValidD, FlushE, RegWriteD, MemWriteD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [1:0]  ResultSrcD;
    logic [31:0] PCPlus4D, ALUResultE, WriteDataE, ReadDataM;
    logic [4:0]  Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteE, MemWriteE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [31:0] PCPlus4E, ALUResultM, WriteDataM, ResultW;
    logic        RegWriteM, MemWriteM, ValidM, RegWriteW, ValidW;
`ifdef RETIRE_CNT_EN
    logic [31:0] RetiredW;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_pipe_regs dut (
`ifdef RETIRE_CNT_EN
        .RetiredW   (RetiredW),
`endif
        .clk        (clk),
        .reset      (reset),
        .ValidD     (ValidD),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .MemWriteD  (MemWriteD),
        .ResultSrcD (ResultSrcD),
        .PCPlus4D   (PCPlus4D),
        .FlushE     (FlushE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .ReadDataM  (ReadDataM),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ValidE     (ValidE),
        .ResultSrcE (ResultSrcE),
        .PCPlus4E   (PCPlus4E),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ValidM     (ValidM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdW        (RdW),
        .RegWriteW  (RegWriteW),
        .ValidW     (ValidW),
        .ResultW    (ResultW)
    );

    // E group: {ValidE, RdE, Rs1E, Rs2E, RegWriteE, MemWriteE, ResultSrcE, PCPlus4E}
    // M group: {ValidM, RdM, RegWriteM, MemWriteM, ALUResultM, WriteDataM}
    // W group: {ValidW, RdW, RegWriteW, ResultW}
    typedef struct {
        logic        v;
        logic        fl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rsrc;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] rdm;
        logic [51:0] exp_e;
        logic [71:0] exp_m;
        logic [38:0] exp_w;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [51:0] grp_e();
        return {ValidE, RdE, Rs1E, Rs2E, RegWriteE, MemWriteE, ResultSrcE, PCPlus4E};
    endfunction
    function automatic logic [71:0] grp_m();
        return {ValidM, RdM, RegWriteM, MemWriteM, ALUResultM, WriteDataM};
    endfunction
    function automatic logic [38:0] grp_w();
        return {ValidW, RdW, RegWriteW, ResultW};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] rsrc,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] rdm);
        ValidD = v;  FlushE = fl;  Rs1D = rs1;  Rs2D = rs2;  RdD = rd;
        RegWriteD = rw;  MemWriteD = mw;  ResultSrcD = rsrc;  PCPlus4D = pc;
        ALUResultE = alu;  WriteDataE = wd;  ReadDataM = rdm;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_e"}, 128'(grp_e()), 128'(0));
        check({tag, "_m"}, 128'(grp_m()), 128'(0));
        check({tag, "_w"}, 128'(grp_w()), 128'(0));
`ifdef RETIRE_CNT_EN
        check({tag, "_retired"}, 128'(RetiredW), 128'(0));
`endif
    endtask

    initial begin
        // v fl rs1 rs2 rd rw mw rsrc pc alu wd rdm | E | M | W
        vecs[0] = '{1'b1, 1'b0, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 32'h0, 32'h0,
                    {1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 2'b01, 32'h100},
                    {1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0},
                    {1'b0, 5'd0, 1'b0, 32'h0}};
        vecs[1] = '{1'b1, 1'b0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 32'h104, 32'h1000, 32'h11, 32'h0,
                    {1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 2'b00, 32'h104},
                    {1'b1, 5'd5, 1'b1, 1'b0, 32'h1000, 32'h11},
                    {1'b0, 5'd0, 1'b0, 32'h0}};
        vecs[2] = '{1'b1, 1'b1, 5'd4, 5'd6, 5'd7, 1'b1, 1'b1, 2'b01, 32'h108, 32'h55, 32'h0, 32'hDEADBEEF,
                    {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0},
                    {1'b1, 5'd0, 1'b0, 1'b0, 32'h55, 32'h0},
                    {1'b1, 5'd5, 1'b1, 32'hDEADBEEF}};
        vecs[3] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 2'b10, 32'h104, 32'h77, 32'h88, 32'h99,
                    {1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 2'b10, 32'h104},
                    {1'b0, 5'd0, 1'b0, 1'b0, 32'h77, 32'h88},
                    {1'b1, 5'd0, 1'b0, 32'h55}};
        vecs[4] = '{1'b1, 1'b0, 5'd8, 5'd9, 5'd0, 1'b0, 1'b1, 2'b00, 32'h200, 32'h2000, 32'hCAFE, 32'h1234,
                    {1'b1, 5'd0, 5'd8, 5'd9, 1'b0, 1'b1, 2'b00, 32'h200},
                    {1'b1, 5'd1, 1'b1, 1'b0, 32'h2000, 32'hCAFE},
                    {1'b0, 5'd0, 1'b0, 32'h77}};
        vecs[5] = '{1'b0, 1'b0, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 2'b01, 32'h300, 32'h5, 32'h6, 32'h7,
                    {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h300},
                    {1'b1, 5'd0, 1'b0, 1'b1, 32'h5, 32'h6},
                    {1'b1, 5'd1, 1'b1, 32'h104}};
        vecs[6] = '{1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 2'b11, 32'h400, 32'hA, 32'hB, 32'hC,
                    {1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 2'b11, 32'h400},
                    {1'b0, 5'd0, 1'b0, 1'b0, 32'hA, 32'hB},
                    {1'b1, 5'd0, 1'b0, 32'h5}};
        vecs[7] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 32'hD, 32'hE, 32'hF0,
                    {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0},
                    {1'b1, 5'd3, 1'b1, 1'b0, 32'hD, 32'hE},
                    {1'b0, 5'd0, 1'b0, 32'hA}};
        vecs[8] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'hF1,
                    {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0},
                    {1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0},
                    {1'b1, 5'd3, 1'b1, 32'hD}};

        // Power-on reset: outputs must be zero before any clock edge.
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        check_all_zero("por");
        @(posedge clk);
        #1 reset = 1'b0;

        // Table: one D-stage slot per cycle, all three groups checked after each edge.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].fl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw,
                  vecs[i].mw, vecs[i].rsrc, vecs[i].pc, vecs[i].alu, vecs[i].wd, vecs[i].rdm);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_e", i), 128'(grp_e()), 128'(vecs[i].exp_e));
            check($sformatf("vec%0d_m", i), 128'(grp_m()), 128'(vecs[i].exp_m));
            check($sformatf("vec%0d_w", i), 128'(grp_w()), 128'(vecs[i].exp_w));
        end

        // Fill E/M/W with valid writes, then reset asynchronously with a flush pending.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 2'b00, 32'h500, 32'h33, 32'h44, 32'h66);
            @(posedge clk);
        end
        #1;
        check("fill_valid_w", 128'({ValidE, ValidM, ValidW}), 128'(3'b111));
        @(negedge clk);
        reset  = 1'b1;
        FlushE = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_flush");
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

        // First instruction after reset reaches W three edges later.
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 2'b00, 32'h600, 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("lat1_e", 128'({ValidE, RdE, ValidM, ValidW}), 128'({1'b1, 5'd4, 1'b0, 1'b0}));
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h42, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("lat2_m", 128'({ValidE, ValidM, RdM, RegWriteM, ValidW}),
              128'({1'b0, 1'b1, 5'd4, 1'b1, 1'b0}));
        @(posedge clk);
        #1;
        check("lat3_w", 128'(grp_w()), 128'({1'b1, 5'd4, 1'b1, 32'h42}));
`ifdef RETIRE_CNT_EN
        check("retired_one", 128'(RetiredW), 128'(1));
`endif
        @(posedge clk);
        #1;
        check("drain_w", 128'({ValidW, RegWriteW}), 128'(2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
